mem_arbiter: RTL and testbench

- Arbitrates the single main-memory port between the instruction cache and the data cache; replaces ad-hoc combinational muxing with a registered, one-transaction-at-a-time scheduler.
- Sits between both Cache2 instances and MainMem.
- Each transfer is one 32-bit word.
- Data requests have priority by default; a starvation guard forces an instruction grant.
- A watchdog aborts transfers for which memory never answers.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: registered one-at-a-time scheduler for the shared main-memory port.
// Data side wins by default; a starvation guard and a watchdog bound every wait.
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  input  logic          i_read,
  input  logic          i_write,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          timeout_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0]    SLIM    = 4'(STARVE_LIMIT);
  localparam logic [7:0]    WD_LAST = 8'(TIMEOUT - 1);
  localparam logic [DW-1:0] BAD     = DW'(32'hDEAD_BEEF);

  logic [1:0]    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic [7:0]    wd_q, wd_d;
  logic          owner_q, owner_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] drd_q, drd_d;
  logic [DW-1:0] ird_q, ird_d;
  logic          drdy_q, drdy_d;
  logic          irdy_q, irdy_d;
  logic          err_q, err_d;

  logic d_act;
  logic i_act;
  logic grant_i;

  assign d_act   = d_read | d_write;
  assign i_act   = i_read | i_write;
  assign grant_i = i_act & (~d_act | (starve_q == SLIM));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wd_d     = wd_q;
    owner_d  = owner_q;
    oe_d     = oe_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    drd_d    = drd_q;
    ird_d    = ird_q;
    drdy_d   = 1'b0;
    irdy_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (d_act | i_act) begin
          state_d = BUSY;
          owner_d = grant_i;
          addr_d  = grant_i ? i_addr : d_addr;
          wdata_d = grant_i ? i_wdata : d_wdata;
          we_d    = grant_i ? i_write : d_write;
          oe_d    = grant_i ? ~i_write : ~d_write;
        end
        // only a data grant over a waiting fetch advances the guard
        if (grant_i | ~i_act) starve_d = '0;
        else if (starve_q != SLIM) starve_d = starve_q + 4'd1;
      end
      BUSY: begin
        wd_d = wd_q + 8'd1;
        if (mem_ready | (wd_q == WD_LAST)) begin
          state_d = RESP;
          oe_d    = 1'b0;
          we_d    = 1'b0;
          wd_d    = '0;
          drdy_d  = ~owner_q;
          irdy_d  = owner_q;
          if (!mem_ready) err_d = 1'b1;
          if (oe_q) begin
            if (owner_q) ird_d = mem_ready ? mem_rdata : BAD;
            else         drd_d = mem_ready ? mem_rdata : BAD;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        wd_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wd_q     <= '0;
      owner_q  <= 1'b0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      drd_q    <= '0;
      ird_q    <= '0;
      drdy_q   <= 1'b0;
      irdy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
      owner_q  <= owner_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      drd_q    <= drd_d;
      ird_q    <= ird_d;
      drdy_q   <= drdy_d;
      irdy_q   <= irdy_d;
      err_q    <= err_d;
    end
  end

  assign mem_oe      = oe_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign d_rdata     = drd_q;
  assign i_rdata     = ird_q;
  assign d_ready     = drdy_q;
  assign i_ready     = irdy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed literal cases, then random traffic against a
// transaction-level model of the arbiter (grant time + answer latency).
module tb_mem_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_read, d_write, i_read, i_write, mem_ready;
  logic [31:0] d_addr, d_wdata, i_addr, i_wdata, mem_rdata;
  logic [31:0] d_rdata, i_rdata, mem_addr, mem_wdata;
  logic        d_ready, i_ready, mem_oe, mem_we, timeout_err;

  mem_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic clr_in();
    d_read = 0; d_write = 0; i_read = 0; i_write = 0;
    d_addr = 0; d_wdata = 0; i_addr = 0; i_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  // One isolated transfer; memory answers on BUSY cycle k (k>TO: never).
  task automatic dxfer(string nm, bit si, bit wr, logic [31:0] a,
                       logic [31:0] wd, logic [31:0] md, int k,
                       int exp_hi, logic [31:0] exp_rd);
    int hi, rdy, bad, other;
    hi = 0; rdy = 0; bad = 0; other = 0;
    @(negedge clk);
    if (si) begin
      i_read = !wr; i_write = wr; i_addr = a; i_wdata = wd;
    end else begin
      d_read = !wr; d_write = wr; d_addr = a; d_wdata = wd;
    end
    for (int c = 1; c <= 40 && rdy == 0; c++) begin
      @(negedge clk);
      mem_ready = 0;
      if (mem_oe | mem_we) begin
        hi++;
        if (mem_addr !== a || mem_wdata !== wd ||
            mem_we !== wr || mem_oe !== !wr) bad++;
      end
      if (si ? d_ready : i_ready) other++;
      if (si ? i_ready : d_ready) rdy = c;
      else if (c == k) begin
        mem_ready = 1; mem_rdata = md;
      end
    end
    d_read = 0; d_write = 0; i_read = 0; i_write = 0;
    check({nm, "_strobe_cycles"}, hi, exp_hi);
    check({nm, "_ready_cycle"}, rdy, exp_hi + 1);
    check({nm, "_hold"}, bad, 0);
    check({nm, "_other_ready"}, other, 0);
    check({nm, "_rdata"}, si ? i_rdata : d_rdata, exp_rd);
  endtask

  // random-phase model state; index 0 = data, 1 = instruction
  bit          act [2];
  bit          wr  [2];
  bit          rb  [2];
  logic [31:0] ra  [2];
  logic [31:0] rw  [2];
  logic [31:0] e_rd [2];
  bit          e_err, busy, own, cwr;
  logic [31:0] ca, cw;
  int          g, n, k, waits, free_at;

  task automatic new_req(int s);
    act[s] = 1;
    wr[s]  = ($urandom % 3 == 0);
    rb[s]  = $urandom % 2;
    ra[s]  = $urandom;
    rw[s]  = $urandom;
  endtask

  initial begin
    logic [9:0] seq;
    int         ng;
    bit         e_stb, e_rdy, gi;

    clr_in();
    reset = 0;
    repeat (3) @(negedge clk);
    check("rst_oe", mem_oe, 0);
    check("rst_we", mem_we, 0);
    check("rst_dready", d_ready, 0);
    check("rst_iready", i_ready, 0);
    check("rst_err", timeout_err, 0);
    check("rst_drdata", d_rdata, 0);
    check("rst_irdata", i_rdata, 0);
    check("rst_addr", mem_addr, 0);
    reset = 1;
    @(negedge clk);
    check("idle_oe", mem_oe, 0);

    dxfer("dread", 0, 0, 32'h100, 32'h0, 32'hCAFEF00D, 2, 2, 32'hCAFEF00D);
    dxfer("dwrite", 0, 1, 32'h40, 32'h12345678, 32'h55555555, 3, 3,
          32'hCAFEF00D);
    dxfer("sim", 1, 0, 32'h80, 32'h0, 32'h0BADC0DE, TO, TO, 32'h0BADC0DE);
    check("sim_err", timeout_err, 0);

    // contention: both keep re-requesting; expect D,D,D,D,I twice
    seq = '0; ng = 0;
    @(negedge clk);
    d_read = 1; d_addr = 32'h10; i_read = 1; i_addr = 32'h20;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      @(negedge clk);
      mem_ready = mem_oe | mem_we;
      mem_rdata = $urandom;
      if (d_ready) begin seq[ng] = 1'b0; ng++; end
      if (i_ready) begin seq[ng] = 1'b1; ng++; end
    end
    d_read = 0; i_read = 0; mem_ready = 0;
    check("contend_count", ng, 10);
    check("contend_order", {22'd0, seq}, 32'h0000_0210);

    dxfer("tmo", 1, 0, 32'h300, 32'h0, 32'h11111111, 99, TO, 32'hDEADBEEF);
    check("tmo_err", timeout_err, 1);
    dxfer("after_tmo", 0, 0, 32'h304, 32'h0, 32'h22222222, 1, 1,
          32'h22222222);
    check("sticky_err", timeout_err, 1);

    @(negedge clk);
    d_read = 1; d_addr = 32'h200;
    for (int c = 0; c < 5 && !mem_oe; c++) @(negedge clk);
    check("midbusy_oe", mem_oe, 1);
    reset = 0;
    #1;
    check("midrst_oe", mem_oe, 0);
    check("midrst_dready", d_ready, 0);
    check("midrst_iready", i_ready, 0);
    check("midrst_err", timeout_err, 0);
    d_read = 0;
    @(negedge clk);
    reset = 1;
    dxfer("post_rst", 0, 0, 32'h300, 32'h0, 32'h13572468, 2, 2,
          32'h13572468);

    // random phase
    @(negedge clk);
    clr_in();
    reset = 0;
    @(negedge clk);
    reset = 1;
    for (int s = 0; s < 2; s++) begin
      act[s] = 0; e_rd[s] = '0;
    end
    e_err = 0; busy = 0; waits = 0; free_at = 0;
    g = 0; n = 0; k = 0; own = 0; cwr = 0; ca = '0; cw = '0;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      e_stb = busy && c >= g + 1 && c <= g + n;
      e_rdy = busy && c == g + n + 1;
      check("oe", mem_oe, e_stb && !cwr);
      check("we", mem_we, e_stb && cwr);
      check("d_ready", d_ready, e_rdy && !own);
      check("i_ready", i_ready, e_rdy && own);
      check("timeout_err", timeout_err, e_err);
      check("d_rdata", d_rdata, e_rd[0]);
      check("i_rdata", i_rdata, e_rd[1]);
      if (e_stb) begin
        check("mem_addr", mem_addr, ca);
        check("mem_wdata", mem_wdata, cw);
      end

      if (e_rdy) begin
        busy = 0;
        free_at = c + 1;
        if ($urandom % 2 == 0) new_req(own);
        else act[own] = 0;
      end
      if (busy && c <= g + n && act[own] && $urandom % 16 == 0)
        act[own] = 0;
      for (int s = 0; s < 2; s++)
        if (!act[s] && $urandom % 4 == 0) new_req(s);

      d_read  = act[0] && (!wr[0] || rb[0]);
      d_write = act[0] && wr[0];
      d_addr  = ra[0];
      d_wdata = rw[0];
      i_read  = act[1] && (!wr[1] || rb[1]);
      i_write = act[1] && wr[1];
      i_addr  = ra[1];
      i_wdata = rw[1];

      mem_rdata = $urandom;
      if (busy && c >= g + 1 && c <= g + n)
        mem_ready = (c == g + k);
      else
        mem_ready = ($urandom % 3 == 0);

      if (busy && c == g + n) begin
        if (k > TO) e_err = 1;
        if (!cwr) e_rd[own] = (k <= TO) ? mem_rdata : 32'hDEADBEEF;
      end

      if (!busy && c >= free_at) begin
        gi = act[1] && (!act[0] || waits == SL);
        if (act[0] || act[1]) begin
          own  = gi;
          busy = 1;
          g    = c;
          cwr  = wr[gi];
          ca   = ra[gi];
          cw   = rw[gi];
          case ($urandom % 10)
            0, 1:    k = TO;
            2:       k = TO + 1 + int'($urandom % 3);
            default: k = 1 + int'($urandom % 4);
          endcase
          n = (k <= TO) ? k : TO;
        end
        if (gi || !act[1]) waits = 0;
        else if (waits < SL) waits++;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
